// File: rtl/oddrx1f_ddr_out_pkg.sv
// oddrx1f_ddr_out_pkg: shared constants for DDR output cells and the PWM blocks that drive them
package oddrx1f_ddr_out_pkg;
  // Idle pad level for PWM outputs, also the default DDR reset level
  localparam bit DDR_OUT_RESET_VALUE = 1'b0;
endpackage

// File: rtl/oddrx1f_ddr_out_if.sv
// oddrx1f_ddr_out_if: DDR output data bundle
//   d0 - high-phase data, d1 - low-phase data, q - serialized pad outputs
//   master drives d0/d1 and observes q; slave is the DDR cell
interface oddrx1f_ddr_out_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] q;
  modport master (output d0, output d1, input q);
  modport slave (input d0, input d1, output q);
endinterface

// File: rtl/oddrx1f_ddr_out_lane.sv
// ddr_out_lane: single-bit x1 DDR output cell with async active-low clear
//   clk_i  - serialization clock, data captured on rising edge
//   rst_ni - asynchronous active-low reset
//   d0_i   - bit shown during the high phase
//   d1_i   - bit shown during the low phase
//   q_o    - serialized output, one cycle after capture
module ddr_out_lane #(
  parameter bit RESET_VALUE   = 1'b0,
  parameter bit INVERT_OUTPUT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d0_i,
  input  logic d1_i,
  output logic q_o
);
  logic s0 = 1'b0, s1 = 1'b0, hi_r = 1'b0, mid_r = 1'b0, lo_r = 1'b0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      hi_r  <= 1'b0;
      mid_r <= 1'b0;
    end else begin
      s0    <= d0_i;
      s1    <= d1_i;
      hi_r  <= s0;
      mid_r <= s1;
    end
  end
  // Low-phase bit is re-timed on the falling edge so the mux leg selected
  // during the low phase never changes while it is selected.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lo_r <= 1'b0;
    else         lo_r <= mid_r;
  end
  // Reset level is an absolute pad level, so it bypasses the inversion.
  always_comb q_o = rst_ni ? ((clk_i ? hi_r : lo_r) ^ INVERT_OUTPUT) : RESET_VALUE;
endmodule

// File: rtl/oddrx1f_ddr_out.sv
// oddrx1f_ddr_out: WIDTH-lane x1 DDR output register
//   clk_i  - serialization clock
//   rst_ni - asynchronous active-low reset
//   bus    - slave side of oddrx1f_ddr_out_if (d0/d1 in, q out)
module oddrx1f_ddr_out
  import oddrx1f_ddr_out_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter bit RESET_VALUE   = DDR_OUT_RESET_VALUE,
  parameter bit INVERT_OUTPUT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  oddrx1f_ddr_out_if.slave bus
);
  logic [WIDTH-1:0] q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ddr_out_lane #(
      .RESET_VALUE  (RESET_VALUE),
      .INVERT_OUTPUT(INVERT_OUTPUT)
    ) u_lane (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d0_i  (bus.d0[i]),
      .d1_i  (bus.d1[i]),
      .q_o   (q[i])
    );
  end
  assign bus.q = q;
endmodule

// File: tb/tb_oddrx1f_ddr_out.sv
// tb_oddrx1f_ddr_out: randomized + directed check of the DDR output register against a sample-history model
module tb_oddrx1f_ddr_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] d0 = 2'b11, d1 = 2'b11;
  int n_chk = 0, n_fail = 0;
  int glitch_cnt = 0;
  bit glitch_win = 1'b0;

  always #5 clk = ~clk;

  oddrx1f_ddr_out_if #(.WIDTH(2)) if_a ();
  oddrx1f_ddr_out_if #(.WIDTH(2)) if_b ();
  assign if_a.d0 = d0;
  assign if_a.d1 = d1;
  assign if_b.d0 = d0;
  assign if_b.d1 = d1;

  oddrx1f_ddr_out #(.WIDTH(2), .RESET_VALUE(1'b0), .INVERT_OUTPUT(1'b0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave));
  oddrx1f_ddr_out #(.WIDTH(2), .RESET_VALUE(1'b1), .INVERT_OUTPUT(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave));

  // Model: history of the last two samples taken since reset; the high phase
  // shows d0 of the older sample, the low phase shows the d1 that was current
  // at the last falling edge.
  logic [3:0] hist[$];
  logic [1:0] lo_exp = 2'b00;

  always @(negedge rst_n) begin
    hist.delete();
    lo_exp = 2'b00;
  end
  always @(posedge clk) if (rst_n) begin
    hist.push_back({d1, d0});
    if (hist.size() > 2) void'(hist.pop_front());
  end
  always @(negedge clk) if (rst_n) lo_exp = (hist.size() == 2) ? hist[0][3:2] : 2'b00;

  function automatic logic [1:0] raw_exp();
    return clk ? ((hist.size() == 2) ? hist[0][1:0] : 2'b00) : lo_exp;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [1:0] r;
    r = raw_exp();
    check("model_a", {30'd0, if_a.q}, {30'd0, rst_n ? r : 2'b00});
    check("model_b", {30'd0, if_b.q}, {30'd0, rst_n ? ~r : 2'b11});
  endtask

  always @(posedge clk or negedge clk) begin
    #2 compare();
    #2 compare();
  end

  always @(if_a.q or if_b.q) if (glitch_win) glitch_cnt++;

  initial begin
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_hi_a", {30'd0, if_a.q}, 32'h0);
      check("rst_hi_b", {30'd0, if_b.q}, 32'h3);
      @(negedge clk); #1;
      check("rst_lo_a", {30'd0, if_a.q}, 32'h0);
      check("rst_lo_b", {30'd0, if_b.q}, 32'h3);
    end
    @(negedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1 check("rel_first_hi", {30'd0, if_a.q}, 32'h0);
    @(negedge clk); #1 check("rel_first_lo", {30'd0, if_a.q}, 32'h0);
    @(posedge clk); #1 check("rel_launch_hi", {30'd0, if_a.q}, 32'h3);
    check("rel_launch_hi_b", {30'd0, if_b.q}, 32'h0);
    @(negedge clk); #1 check("rel_launch_lo", {30'd0, if_a.q}, 32'h3);
    glitch_win = 1'b1;
    repeat (10) @(posedge clk);
    glitch_win = 1'b0;
    check("const_no_glitch", glitch_cnt, 0);
    @(negedge clk); d0 = 2'b00; d1 = 2'b11;
    @(posedge clk); @(posedge clk); #1 check("01_hi", {30'd0, if_a.q}, 32'h0);
    @(negedge clk); #1 check("01_lo", {30'd0, if_a.q}, 32'h3);
    d0 = 2'b01; d1 = 2'b10;
    @(posedge clk); @(posedge clk); #1;
    check("lanes_hi_a", {30'd0, if_a.q}, 32'h1);
    check("lanes_hi_b", {30'd0, if_b.q}, 32'h2);
    @(negedge clk); #1;
    check("lanes_lo_a", {30'd0, if_a.q}, 32'h2);
    check("lanes_lo_b", {30'd0, if_b.q}, 32'h1);
    d0 = 2'b11; d1 = 2'b00;
    @(posedge clk); @(posedge clk); #1 check("alt_hi", {30'd0, if_a.q}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("midhi_rst_a", {30'd0, if_a.q}, 32'h0);
    check("midhi_rst_b", {30'd0, if_b.q}, 32'h3);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (400) begin
      @(negedge clk);
      d0 = 2'($urandom);
      d1 = 2'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(posedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/oddrx1f_ddr_out.md
Name: oddrx1f_ddr_out

Overview:
- Generic, technology-independent double-data-rate output register. Models the x1 DDR output cell: serializes two bits per clock onto one output, first on the high phase and second on the low phase.
- Sits at the I/O boundary, driven by PWM generators; each instance drives one pad per lane.
- Gives a 2x-clock time resolution for PWM edges and dead-time without a faster clock.

Parameters:
- WIDTH, 1, number of independent DDR lanes (bits of d0_i/d1_i/q_o).
- RESET_VALUE, 0, value of every q_o bit while reset is asserted (per-lane replicated 1-bit constant).
- INVERT_OUTPUT, 0, when 1 each q_o bit is the logical inverse of the serialized data; RESET_VALUE is applied after inversion (absolute pad level).

Ports:
- clk_i  input  1  serialization clock; data sampled on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- d0_i  input  WIDTH  data for the high phase.
- d1_i  input  WIDTH  data for the low phase.
- q_o  output  WIDTH  serialized DDR output.

Behaviour:
- Reset: rst_ni low immediately (no clock) forces all internal registers to 0 and q_o to RESET_VALUE regardless of clock phase. Held while low.
- Capture: at every posedge k with rst_ni high, s0 <= d0_i and s1 <= d1_i (capture stage).
- Launch: at posedge k+1, hi_r <= s0 and mid_r <= s1.
- Low-phase register: at negedge following posedge k+1, lo_r <= mid_r. The low-phase value is re-timed on the falling edge so the mux never passes a changing value.
- Output: q_o = (clk_i ? hi_r : lo_r) ^ INVERT_OUTPUT, forced to RESET_VALUE while rst_ni low.
- Latency: d0_i sampled at posedge k is on q_o from posedge k+1 to the next negedge. d1_i from the same sample is on q_o from that negedge to posedge k+2. This is a fixed 1-cycle latency, identical for every lane.
- Lanes are fully independent with no cross-lane logic.
- Reset release: the first posedge after rst_ni rises captures data. q_o shows the internal zeros (^INVERT_OUTPUT) until the captured data launches one cycle later. The low-phase register is still zero until its own negedge.
- Reset asserted mid-cycle (either phase) clears state at once. No stale data is emitted after reset release.
- d0_i == d1_i produces a full-cycle constant level with no glitch at negedge or posedge. The mux output must be glitch-free for equal inputs, so mux select timing is the only transition source.
- All registers have async-clear on rst_ni. No synchronous reset, no enable input (tie-off via d0_i/d1_i).
- Simulation initial value: every register is 0 (matches reset).

Decomposition:
- Shared package: none required. Optionally add a localparam for the default RESET_VALUE of the PWM outputs, consumed by PWM blocks.
- One sub-module: ddr_out_lane (single-bit capture/launch/negedge/mux with async clear), replicated WIDTH times by generate in oddrx1f_ddr_out.

Test Plan:
- Reset: hold rst_ni=0 across 4 cycles with d0_i=1, d1_i=1, RESET_VALUE=0 -> q_o=0 in both phases. Assert rst_ni=0 mid-high-phase while q_o=1 -> q_o=0 within the same delta, without waiting for a clock edge.
- Alternating pattern: d0_i=1, d1_i=0 sampled at posedge 5 -> q_o=1 from posedge 6 to negedge 6, then 0 until posedge 7. Repeated every cycle, q_o is a copy of clk_i delayed one cycle.
- Constant: d0_i=d1_i=1 for 10 cycles -> q_o holds 1 continuously from posedge k+1 with no 0 pulse at any edge. Then switch to d0_i=0, d1_i=1 -> q_o 0 high-phase, 1 low-phase.
- Inversion: INVERT_OUTPUT=1, RESET_VALUE=1, data d0_i=1, d1_i=0 -> q_o=0 high-phase, 1 low-phase; during reset q_o=1.
- Multi-lane: WIDTH=2, lane0 d0/d1=1/0, lane1 d0/d1=0/1 -> lanes opposite in each half-cycle with identical 1-cycle latency.
- Reset release: rst_ni rises just before posedge 3 with d0_i=d1_i=1 -> q_o stays 0 through cycle 3, becomes 1 at posedge 4 and stays 1 through the following low phase.
